// File: rtl/knn_topk_sorter.sv
// Streaming top-K selector for k-NN: keeps the K smallest distances (with labels)
// in an ascending insertion-sorted buffer, then drains them smallest-first.
module knn_topk_sorter #(
    parameter int W      = 16,
    parameter int TYPE_W = 4,
    parameter int K      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_dist,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_dist,
    output logic [TYPE_W-1:0] out_type,
    output logic              out_last,
    output logic              busy
);
    localparam int CW = $clog2(K + 1);
    localparam int RW = $clog2(K);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      dist_q [K];
    logic [W-1:0]      dist_d [K];
    logic [TYPE_W-1:0] type_q [K];
    logic [TYPE_W-1:0] type_d [K];
    logic [K-1:0]      valid_q, valid_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [K-1:0]      ins, ins_prev;
    logic              accept, last_entry;

    // ins is monotonic over a sorted buffer, so the first set bit is the insertion
    // point and every set bit above it takes the entry from the slot below.
    always_comb begin
        ins = '0;
        for (int unsigned i = 0; i < K; i++) begin
            ins[i] = !valid_q[i] || (in_dist < dist_q[i]);
        end
    end

    assign ins_prev   = {ins[K-2:0], 1'b0};
    assign accept     = (state_q == FILL) && in_valid;
    assign last_entry = (CW'(rd_q) == (count_q - 1'b1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        dist_d  = dist_q;
        type_d  = type_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    valid_d = '0;
                    count_d = '0;
                    rd_d    = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    for (int unsigned i = 1; i < K; i++) begin
                        if (ins_prev[i]) begin
                            dist_d[i]  = dist_q[i-1];
                            type_d[i]  = type_q[i-1];
                            valid_d[i] = valid_q[i-1];
                        end
                    end
                    for (int unsigned i = 0; i < K; i++) begin
                        if (ins[i] && !ins_prev[i]) begin
                            dist_d[i]  = in_dist;
                            type_d[i]  = in_type;
                            valid_d[i] = 1'b1;
                        end
                    end
                    if (count_q < CW'(K)) begin
                        count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (last_entry) begin
                        rd_d    = '0;
                        state_d = IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            rd_q    <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                type_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                type_q[i] <= type_d[i];
            end
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_dist  = out_valid ? dist_q[rd_q] : '0;
    assign out_type  = out_valid ? type_q[rd_q] : '0;
    assign out_last  = out_valid && last_entry;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_knn_topk_sorter.sv
// Randomised bench for knn_topk_sorter (K=4, W=8, TYPE_W=4) against a stable-sort
// reference: the result is the first K of all accepted samples sorted by distance.
module tb_knn_topk_sorter;
    localparam int K = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] t;
        logic       l;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_dist = '0;
    logic [3:0] in_type = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_dist;
    logic [3:0] out_type;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int hold_viol;
    bit timeout;
    ent_t stim_q[$];
    ent_t got_q[$];
    ent_t exp_q[$];

    knn_topk_sorter #(.W(8), .TYPE_W(4), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .in_type(in_type), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
        .out_type(out_type), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void build_exp();
        exp_q.delete();
        foreach (stim_q[i]) begin
            int j = 0;
            ent_t e = stim_q[i];
            e.l = 1'b0;
            while (j < exp_q.size() && exp_q[j].d <= e.d) j++;
            exp_q.insert(j, e);
        end
        while (exp_q.size() > K) exp_q.pop_back();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].l = 1'b1;
    endfunction

    function automatic ent_t mk(input int d, input int t, input bit l);
        ent_t e;
        e.d = d[7:0];
        e.t = t[3:0];
        e.l = l;
        return e;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_all(input int gap_max);
        foreach (stim_q[i]) begin
            int n = 0;
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            in_valid = 1'b1;
            in_dist  = stim_q[i].d;
            in_type  = stim_q[i].t;
            in_last  = stim_q[i].l;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 50) begin
                errors++;
                $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int mode);
        int  cyc = 0;
        int  ph = 0;
        bit  held = 0;
        bit  done = 0;
        ent_t h;
        got_q.delete();
        timeout = 0;
        hold_viol = 0;
        while (!done) begin
            if (cyc >= 300) begin
                timeout = 1;
                break;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (ph >= 2) && (ph % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (held && (!out_valid || {out_dist, out_type, out_last} != h)) hold_viol++;
            held = 0;
            if (out_valid) begin
                h = {out_dist, out_type, out_last};
                held = !out_ready;
                if (out_ready) begin
                    got_q.push_back(h);
                    if (out_last) done = 1;
                end
            end
            ph++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        #12;
        checks++;
        if ({in_ready, out_valid, out_dist, out_type, out_last, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b ov=%0b d=%0d t=%0d l=%0b busy=%0b required all 0",
                     in_ready, out_valid, out_dist, out_type, out_last, busy);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b in_ready=%0b out_valid=%0b required 0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_fixed(input string name, input int mode);
        build_exp();
        do_start();
        send_all(1);
        collect(mode);
        checks++;
        if (timeout || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d entries (timeout=%0b) required %0d", name, got_q.size(), timeout, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_entry%0d: got d=%0d t=%0d l=%0b required d=%0d t=%0d l=%0b", name, i,
                         got_q[i].d, got_q[i].t, got_q[i].l, exp_q[i].d, exp_q[i].t, exp_q[i].l);
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b out_valid=%0b required 0", name, busy, out_valid);
        end
    endtask

    task automatic test_basic();
        stim_q = '{mk(50,1,0), mk(20,2,0), mk(90,3,0), mk(10,4,0), mk(70,5,0), mk(30,6,1)};
        test_fixed("basic", 0);
        stim_q = '{mk(40,1,0), mk(40,2,0), mk(40,3,1)};
        test_fixed("ties", 0);
        stim_q = '{mk(200,7,1)};
        test_fixed("single", 0);
        stim_q = '{mk(5,1,0), mk(6,2,0), mk(7,3,0), mk(8,4,0), mk(8,9,0), mk(255,5,1)};
        test_fixed("drop", 0);
    endtask

    task automatic test_backpressure();
        stim_q = '{mk(9,1,0), mk(3,2,0), mk(7,3,0), mk(1,4,0), mk(3,5,1)};
        test_fixed("bp", 1);
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d hold violations required 0", hold_viol);
        end
    endtask

    task automatic test_ignore();
        // in_valid in IDLE must not be accepted
        @(negedge clk);
        in_valid = 1'b1;
        in_dist  = 8'd1;
        in_type  = 4'd1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: in_ready=%0b required 0", in_ready);
        end
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        // start pulse mid-FILL and mid-DRAIN must not restart the query
        do_start();
        stim_q = '{mk(60,2,0), mk(15,3,0)};
        send_all(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim_q = '{mk(33,4,1)};
        send_all(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim_q = '{mk(60,2,0), mk(15,3,0), mk(33,4,1)};
        build_exp();
        collect(0);
        checks++;
        if (timeout || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ignore_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ignore_entry%0d: got d=%0d t=%0d l=%0b required d=%0d t=%0d l=%0b", i,
                         got_q[i].d, got_q[i].t, got_q[i].l, exp_q[i].d, exp_q[i].t, exp_q[i].l);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        stim_q = '{mk(1,1,0), mk(2,2,0)};
        send_all(0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_dist, out_type, out_last, busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%0b ov=%0b d=%0d t=%0d l=%0b busy=%0b required all 0",
                     in_ready, out_valid, out_dist, out_type, out_last, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: out_valid=%0b busy=%0b required 0", out_valid, busy);
        end
        stim_q = '{mk(3,1,1)};
        test_fixed("midreset", 0);
    endtask

    task automatic test_random();
        for (int q = 0; q < 15; q++) begin
            int n = $urandom_range(1, 9);
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                stim_q.push_back(mk($urandom_range(0, 20), $urandom_range(0, 15), i == n - 1));
            end
            test_fixed("rand", $urandom_range(0, 2));
            checks++;
            if (hold_viol != 0) begin
                errors++;
                $display("FAIL rand_hold: %0d hold violations required 0", hold_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_topk_sorter.md
KNN_TOPK_SORTER -- requirements
Module: knn_topk_sorter

Interface
REQ-001 SHALL have parameter W, default 16: distance width in bits (unsigned).
REQ-002 SHALL have parameter TYPE_W, default 4: class-label width in bits.
REQ-003 SHALL have parameter K, default 8: number of nearest neighbours retained (K>=2).
REQ-004 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse: clear buffer, begin a new query.
REQ-007 SHALL have port in_valid  input  1  sample valid.
REQ-008 SHALL have port in_ready  output  1  sorter accepts a sample this cycle.
REQ-009 SHALL have port in_dist  input  W  sample distance.
REQ-010 SHALL have port in_type  input  TYPE_W  sample class label.
REQ-011 SHALL have port in_last  input  1  marks the final sample of the query.
REQ-012 SHALL have port out_valid  output  1  result entry valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts a result entry.
REQ-014 SHALL have port out_dist  output  W  result distance.
REQ-015 SHALL have port out_type  output  TYPE_W  result label.
REQ-016 SHALL have port out_last  output  1  marks the final result entry.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, FILL, DRAIN.
REQ-019 IDLE: start=1 -> clear all K slot-valid flags and count, go to FILL next cycle; start SHALL be ignored in FILL and DRAIN.
REQ-020 FILL: in_ready=1; a sample is accepted when in_valid&&in_ready; no other state asserts in_ready.
REQ-021 Buffer: K slots {dist,type,valid}, slot 0 smallest, kept ascending by distance at every clock edge.
REQ-022 On accept: insertion index p = lowest i with !valid[i] or in_dist < dist[i] (strict, unsigned); slots p..K-2 shift to p+1..K-1, slot K-1 discarded; new sample written at p; update complete in the accepting cycle (visible next cycle).
REQ-023 If no such p exists (buffer full, in_dist >= dist[K-1]), the sample SHALL be dropped, buffer unchanged.
REQ-024 Ties: equal distances keep arrival order (earlier sample at lower index); type always travels with its distance.
REQ-025 count SHALL saturate at K; increments on each accept while count<K.
REQ-026 Accept with in_last=1 -> DRAIN next cycle, that sample included; throughput one sample per cycle, no bubbles.
REQ-027 DRAIN: read index r starts 0; out_valid=1; out_dist/out_type = slot r; out_last = (r==count-1).
REQ-028 DRAIN: out_valid&&out_ready -> r increments; on transfer with out_last=1 -> IDLE next cycle; outputs SHALL hold stable while out_valid&&!out_ready.
REQ-029 out_valid SHALL be 0 outside DRAIN; out_dist/out_type/out_last SHALL be 0 when out_valid=0.
REQ-030 start coincident with rst_n=0 SHALL be ignored; in_valid in IDLE/DRAIN SHALL be ignored (not accepted).

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, all slot dist/type/valid to 0, count 0, r 0.
REQ-032 During and immediately after reset: in_ready=0, out_valid=0, out_dist=0, out_type=0, out_last=0, busy=0.
REQ-033 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the query; no partial results emitted after release.

Verification (K=4, W=8, TYPE_W=4)
REQ-034 Samples (dist,type) (50,1)(20,2)(90,3)(10,4)(70,5)(30,6) last=6th, out_ready=1 -> out (10,4)(20,2)(30,6)(50,1), out_last on 4th, busy low after.
REQ-035 Ties: (40,1)(40,2)(40,3) last -> out (40,1)(40,2)(40,3), out_last on 3rd (count=3 < K).
REQ-036 Single sample (200,7) with in_last -> one entry (200,7), out_last=1, then IDLE.
REQ-037 Backpressure: out_ready toggles 0,0,1,0,1,... -> each entry held unchanged until accepted, no loss or duplication.
REQ-038 Full buffer {5,6,7,8}, sample (8,9) -> dropped; sample (255,x) -> dropped; result unchanged.
REQ-039 rst_n pulsed low after 2 samples in FILL -> outputs zero immediately; new start + (3,1) last -> only (3,1) output.
